// File: rtl/clock_div_multi.sv
// ---------------------------------------------------------------------------
// clock_div_multi
//   Multi-channel programmable clock divider. Each channel produces a 50 %
//   duty square wave with a run-time half-period, plus a one-cycle tick on
//   every rising edge of its output. Divisor changes and disables only take
//   effect when the output falls, so outputs never glitch. A sync request
//   phase-aligns every channel.
//
// Ports
//   clock_in    system clock, rising edge
//   reset       asynchronous, active-high
//   enable      per-channel run enable (level)
//   sync_pulse  one-cycle request to phase-align all channels
//   cfg_valid   divisor write request
//   cfg_chan    target channel of the write
//   cfg_half    new half-period in clock_in cycles
//   cfg_ready   write can be accepted this cycle
//   cfg_err     one-cycle pulse after a rejected write
//   clock_out   divided clocks (registered)
//   tick_out    one-cycle strobe with each clock_out rise (registered)
// ---------------------------------------------------------------------------
module clock_div_multi #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int DEFAULT_HALF = 6000,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_pulse,
  input  logic                cfg_valid,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_half,
  output logic                cfg_ready,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick_out
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  logic [CHANNELS-1:0] pend_v_all;
  logic                chan_ok_d;
  logic                bad_d;
  logic                accept_d;
  logic                sync_q;
  logic                err_q;

  // Config decode. An out-of-range channel reports ready so the request is
  // taken and flagged as an error instead of stalling the writer forever.
  assign chan_ok_d = (32'(cfg_chan) < 32'(CHANNELS));
  assign cfg_ready = chan_ok_d ? !pend_v_all[cfg_chan] : 1'b1;
  assign bad_d     = cfg_valid && ((cfg_half == '0) || !chan_ok_d);
  assign accept_d  = cfg_valid && !bad_d && cfg_ready;
  assign cfg_err   = err_q;

  // Sync is registered, so a pulse sampled at edge s realigns at edge s+1.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= sync_pulse;
      err_q  <= bad_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] half_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_v_q;
    logic             clk_q;
    logic             tick_q;
    logic             wrap_d;
    logic             acc_d;

    assign wrap_d        = (cnt_q == half_q - WIDTH'(1));
    assign acc_d         = accept_d && (cfg_chan == CW'(c));
    assign pend_v_all[c] = pend_v_q;
    assign clock_out[c]  = clk_q;
    assign tick_out[c]   = tick_q;

    // Pending divisor payload; qualified by pend_v_q so it needs no reset.
    always_ff @(posedge clock_in) begin
      if (acc_d) pend_q <= cfg_half;
    end

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        half_q   <= WIDTH'(DEFAULT_HALF);
        pend_v_q <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        // An accept only happens with pend_v_q clear, so it never collides
        // with a pending-apply below.
        if (acc_d) pend_v_q <= 1'b1;

        if (sync_q) begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          if (pend_v_q) begin
            half_q   <= pend_q;
            pend_v_q <= 1'b0;
          end
          if (state_q == STOPPING) state_q <= IDLE;
        end else if (state_q == IDLE) begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          if (pend_v_q) begin
            half_q   <= pend_q;
            pend_v_q <= 1'b0;
          end
          if (enable[c]) state_q <= RUN;
        end else if ((state_q == RUN) && !enable[c] && !clk_q) begin
          // Already low: nothing to finish, stop straight away.
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          // RUN and STOPPING count identically; re-enable resumes in phase.
          state_q <= enable[c] ? RUN : STOPPING;
          if (wrap_d) begin
            cnt_q <= '0;
            clk_q <= !clk_q;
            if (!clk_q) begin
              tick_q <= 1'b1;
            end else begin
              // Falling edge is the period boundary.
              if (pend_v_q) begin
                half_q   <= pend_q;
                pend_v_q <= 1'b0;
              end
              if (!enable[c]) state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
